inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Write-side counterpart of the instruction ROM. It accepts decoded RV32I fields one beat at a time.
//  Each beat is packed into a 32-bit R-type or I-type word and written sequentially into an instruction RAM from address 0.
//  On iLast or capacity-full, it appends the mandatory trailing NO-OP (32'h0).
//  Used by the bench/boot path to load programs instead of hard-coded ROM init.
// PARAMETERS
//  WIDTH     32   instruction word width (only 32 supported)
//  NUM_INST  15   memory depth in words, including the reserved final NO-OP slot
//  ADDR_W    4    write address width, $clog2(NUM_INST)
// PORTS
//  iClk      in   1       clock; single clock domain
//  iRstN     in   1       synchronous, active-low reset
//  iStart    in   1       begin a load; honoured in IDLE or DONE only
//  iValid    in   1       field beat valid
//  oReady    out  1       loader can accept a beat; transfer = iValid & oReady
//  iLast     in   1       qualifies the final user beat
//  iOpcode   in   7       7'h33 = R-type, 7'h13 = I-type; anything else is an error
//  iRd, iRs1, iRs2  in  5 each  register fields (iRs2 is ignored for I-type)
//  iFunct3   in   3       funct3
//  iFunct7   in   7       funct7 (R-type only)
//  iImm      in   12      I-type immediate (shifts carry funct7 in imm[11:5])
//  oWe       out  1       RAM write enable, one-cycle pulse per word
//  oWaddr    out  ADDR_W  RAM write address
//  oWdata    out  WIDTH   RAM write data
//  oBusy     out  1       state is LOAD or TERM
//  oDone     out  1       held high in DONE
//  oError    out  1       sticky: an unsupported opcode was seen during this load
//  oCount    out  ADDR_W  user words written in this load, excluding the NO-OP
// BEHAVIOUR
//  Reset: state=IDLE; oWe=0, oWaddr=0, oWdata=0, oReady=0, oBusy=0, oDone=0, oError=0, oCount=0.
//  Reset mid-load aborts the load with no NO-OP written; reset wins over every other input.
//  FSM transitions:
//   IDLE -iStart-> LOAD; the same edge clears oCount and oError and sets the write pointer to 0.
//   LOAD: oReady=1. Each transfer registers one write, so oWe is high on the next cycle at the current pointer.
//    After a valid write, the pointer and oCount increment.
//   LOAD -> TERM when a transfer has iLast=1, or when that transfer makes oCount reach NUM_INST-1.
//   TERM: oReady=0; write 32'h0 at the pointer for one cycle, then go to DONE.
//   DONE: oDone=1; iStart re-enters LOAD (restart from address 0, oError cleared).
//  Packing:
//   R-type: {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpcode}.
//   I-type: {iImm, iRs1, iFunct3, iRd, iOpcode}.
//  Unsupported opcode: the beat is accepted but no write occurs, the pointer is not advanced, and oError is set.
//   iLast on such a beat still goes to TERM.
//  iLast with zero valid words: only the NO-OP is written, at address 0.
//  iStart while oBusy is ignored. iValid outside LOAD is ignored.
//  Latency: 1 cycle from transfer to oWe. Throughput: 1 word per cycle. Worst case NUM_INST+1 cycles per load.
// CONFIGURATION
//  INST_LOADER_CHECKSUM_EN defined:
//   Adds output oChecksum[WIDTH-1:0], the XOR of all oWdata words written this load, NO-OP included.
//   Cleared on reset and on load start; valid when oDone=1.
//  INST_LOADER_CHECKSUM_EN undefined: the port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package rv_inst_pkg:
//   OPC_RTYPE=7'h33, OPC_ITYPE=7'h13, NOP_WORD=32'h0.
//   Field typedef (rd/rs1/rs2/funct3/funct7/opcode/imm).
//   loader_state_t {IDLE, LOAD, TERM, DONE}.
//  One combinational sub-module, inst_encoder: fields -> {word, supported}.
//  The FSM, pointer/count and write-port registers live in inst_loader.
// TESTING
//  Full program:
//   Stream 14 beats (ADDI x1,x1,10; ... SRA x14,x10,x5), iLast on the 14th.
//   Expect writes at 0..13: 0x00A08093, 0x00A10113, 0x001101B3, ..., 0x40555733, then 0x0 at 14.
//   Expect oCount=14, oDone=1.
//  Encoding corners:
//   ADD rd=3, rs1=2, rs2=1 -> 0x001101B3.
//   SRAI rd=13, rs1=10, imm=0x405 -> 0x40555693.
//   SUB rd=10, rs1=2, rs2=6, funct7=0x20 -> 0x40610533.
//  Capacity: 20 beats, no iLast -> exactly 14 user writes, NO-OP at 14, oReady low from the 15th beat on, oCount=14.
//  Bad opcode: beat 2 with opcode 0x03 -> no write, oError=1, next valid beat written at addr 2.
//  Backpressure/restart:
//   Gaps in iValid produce no oWe.
//   iStart mid-load is ignored.
//   iStart in DONE reloads from address 0 with oError cleared.
//  Reset mid-load: iRstN=0 after 5 beats -> next cycle all outputs are at reset values and no NO-OP is written.
//   With CHECKSUM_EN, oChecksum equals the XOR computed by the model.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared RV32I loader definitions: opcodes, NO-OP word, field bundle and loader states.
package rv_inst_pkg;

   localparam logic [6:0]  OPC_RTYPE = 7'h33;
   localparam logic [6:0]  OPC_ITYPE = 7'h13;
   localparam logic [31:0] NOP_WORD  = 32'h0;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [11:0] imm;
   } inst_fields_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      TERM = 2'd2,
      DONE = 2'd3
   } loader_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Field-beat handshake between an instruction source (master) and the loader (slave).
interface inst_loader_if;
   logic        iValid;
   logic        oReady;
   logic        iLast;
   logic [6:0]  iOpcode;
   logic [4:0]  iRd;
   logic [4:0]  iRs1;
   logic [4:0]  iRs2;
   logic [2:0]  iFunct3;
   logic [6:0]  iFunct7;
   logic [11:0] iImm;

   modport master (
      output iValid, iLast, iOpcode, iRd, iRs1, iRs2, iFunct3, iFunct7, iImm,
      input  oReady
   );

   modport slave (
      input  iValid, iLast, iOpcode, iRd, iRs1, iRs2, iFunct3, iFunct7, iImm,
      output oReady
   );
endinterface

// File: rtl/inst_loader_encoder.sv
// Packs decoded RV32I fields into an R-type or I-type word; flags unsupported opcodes.
module inst_encoder
   import rv_inst_pkg::*;
(
   input  inst_fields_t i_fields,
   output logic [31:0]  o_word,
   output logic         o_supported
);

   // Select the packing from the opcode; anything else yields no word.
   always_comb begin
      o_word      = NOP_WORD;
      o_supported = 1'b0;
      case (i_fields.opcode)
         OPC_RTYPE: begin
            o_word      = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, i_fields.rd, i_fields.opcode};
            o_supported = 1'b1;
         end
         OPC_ITYPE: begin
            o_word      = {i_fields.imm, i_fields.rs1,
                           i_fields.funct3, i_fields.rd, i_fields.opcode};
            o_supported = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/inst_loader.sv
// Instruction RAM loader: packs field beats into words, writes them from address 0
// and closes every load with a NO-OP word.
// Optional build macro: INST_LOADER_CHECKSUM_EN adds oChecksum (XOR of all words
// written in the current load, NO-OP included).
//
//  state | meaning
//  IDLE  | waiting for iStart after reset
//  LOAD  | accepting beats, one registered write per supported beat
//  TERM  | issuing the trailing NO-OP write at the pointer
//  DONE  | load complete, oDone high, iStart reloads from address 0
module inst_loader
   import rv_inst_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_INST = 15,
   parameter int ADDR_W   = $clog2(NUM_INST)
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iStart,
   inst_loader_if.slave      bus,
   output logic              oWe,
   output logic [ADDR_W-1:0] oWaddr,
   output logic [WIDTH-1:0]  oWdata,
   output logic              oBusy,
   output logic              oDone,
   output logic              oError,
   output logic [ADDR_W-1:0] oCount
`ifdef INST_LOADER_CHECKSUM_EN
   ,
   output logic [WIDTH-1:0]  oChecksum
`endif
);

   loader_state_t     r_state;
   loader_state_t     w_state_nxt;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [WIDTH-1:0]  r_wdata;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_count;
   logic              r_error;
   inst_fields_t      w_fields;
   logic [31:0]       w_word;
   logic              w_supported;
   logic              w_xfer;
   logic              w_start;
   logic              w_cap_hit;

   assign w_fields = '{opcode: bus.iOpcode, rd: bus.iRd, rs1: bus.iRs1, rs2: bus.iRs2,
                       funct3: bus.iFunct3, funct7: bus.iFunct7, imm: bus.iImm};

   inst_encoder u_encoder (
      .i_fields    (w_fields),
      .o_word      (w_word),
      .o_supported (w_supported)
   );

   assign w_xfer    = bus.iValid && (r_state == LOAD);
   assign w_start   = iStart && ((r_state == IDLE) || (r_state == DONE));
   // This beat's write fills the last user slot; the final slot is kept for the NO-OP.
   assign w_cap_hit = w_supported && (r_count == ADDR_W'(NUM_INST - 2));

   // State register.
   always_ff @(posedge iClk) begin
      if (!iRstN) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and state-decoded handshake/status outputs.
   always_comb begin
      w_state_nxt = r_state;
      bus.oReady  = 1'b0;
      oBusy       = 1'b0;
      oDone       = 1'b0;
      case (r_state)
         IDLE: if (iStart) w_state_nxt = LOAD;
         LOAD: begin
            bus.oReady = 1'b1;
            oBusy      = 1'b1;
            if (w_xfer && (bus.iLast || w_cap_hit)) w_state_nxt = TERM;
         end
         TERM: begin
            oBusy       = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            oDone = 1'b1;
            if (iStart) w_state_nxt = LOAD;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Write port, pointer, count and sticky error; oWe is a single-cycle pulse per word.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_ptr   <= '0;
         r_count <= '0;
         r_error <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_start) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_error <= 1'b0;
         end else if (w_xfer) begin
            if (w_supported) begin
               r_we    <= 1'b1;
               r_waddr <= r_ptr;
               r_wdata <= w_word;
               r_ptr   <= r_ptr + ADDR_W'(1);
               r_count <= r_count + ADDR_W'(1);
            end else begin
               r_error <= 1'b1;
            end
         end else if (r_state == TERM) begin
            r_we    <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= NOP_WORD;
         end
      end
   end

`ifdef INST_LOADER_CHECKSUM_EN
   logic [WIDTH-1:0] r_checksum;

   // Running XOR of every word handed to the write port during this load.
   always_ff @(posedge iClk) begin
      if (!iRstN)                       r_checksum <= '0;
      else if (w_start)                 r_checksum <= '0;
      else if (w_xfer && w_supported)   r_checksum <= r_checksum ^ w_word;
      else if (r_state == TERM)         r_checksum <= r_checksum ^ NOP_WORD;
   end

   assign oChecksum = r_checksum;
`endif

   assign oWe    = r_we;
   assign oWaddr = r_waddr;
   assign oWdata = r_wdata;
   assign oError = r_error;
   assign oCount = r_count;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed programs plus randomized loads
// compared against a list-level reference model of the expected RAM writes.
module tb_inst_loader;

   logic        iClk  = 1'b0;
   logic        iRstN = 1'b0;
   logic        iStart = 1'b0;
   logic        oWe;
   logic [3:0]  oWaddr;
   logic [31:0] oWdata;
   logic        oBusy, oDone, oError;
   logic [3:0]  oCount;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [31:0] oChecksum;
`endif

   always #5 iClk = ~iClk;

   inst_loader_if bus ();

   inst_loader dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iStart (iStart),
      .bus    (bus),
      .oWe    (oWe),
      .oWaddr (oWaddr),
      .oWdata (oWdata),
      .oBusy  (oBusy),
      .oDone  (oDone),
      .oError (oError),
      .oCount (oCount)
`ifdef INST_LOADER_CHECKSUM_EN
      ,
      .oChecksum (oChecksum)
`endif
   );

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] imm;
      bit          last;
   } beat_t;

   int          n_chk = 0;
   int          n_fail = 0;
   beat_t       beats[$];
   logic [35:0] wq[$];
   logic [35:0] exp_w[$];
   int          exp_cnt, exp_acc;
   bit          exp_err;
   int          acc_cnt, rej_cnt;

   // Write-port monitor, sampled mid-cycle.
   always @(negedge iClk) if (oWe === 1'b1) wq.push_back({oWaddr, oWdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge iClk);
      #1;
   endtask

   function automatic beat_t mk(input int op, rd, rs1, rs2, f3, f7, imm, input bit last);
      beat_t b;
      b.op = 7'(op); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
      b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = 12'(imm); b.last = last;
      return b;
   endfunction

   function automatic beat_t rand_beat(input int bad_pct);
      beat_t b;
      b = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
      if ($urandom_range(99) < bad_pct) begin
         if (b.op == 7'h33 || b.op == 7'h13) b.op = 7'h03;
      end else begin
         b.op = ($urandom_range(1) == 1) ? 7'h33 : 7'h13;
      end
      return b;
   endfunction

   function automatic bit is_supp(input logic [6:0] op);
      return (op == 7'h33) || (op == 7'h13);
   endfunction

   function automatic logic [31:0] pack(input beat_t b);
      if (b.op == 7'h33) return {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
      return {b.imm, b.rs1, b.f3, b.rd, b.op};
   endfunction

   // Reference: walk the beat list, stop at iLast or when 14 user words exist, add NO-OP.
   task automatic model();
      exp_w.delete();
      exp_cnt = 0; exp_err = 0; exp_acc = 0;
      for (int i = 0; i < beats.size(); i++) begin
         exp_acc++;
         if (is_supp(beats[i].op)) begin
            exp_w.push_back({4'(exp_cnt), pack(beats[i])});
            exp_cnt++;
         end else begin
            exp_err = 1'b1;
         end
         if (beats[i].last || exp_cnt == 14) break;
      end
      exp_w.push_back({4'(exp_cnt), 32'h0});
   endtask

   task automatic bus_idle();
      bus.iValid = 0; bus.iLast = 0; bus.iOpcode = 0; bus.iRd = 0; bus.iRs1 = 0;
      bus.iRs2 = 0; bus.iFunct3 = 0; bus.iFunct7 = 0; bus.iImm = 0;
   endtask

   task automatic send(input beat_t b, output bit acc);
      bus.iOpcode = b.op; bus.iRd = b.rd; bus.iRs1 = b.rs1; bus.iRs2 = b.rs2;
      bus.iFunct3 = b.f3; bus.iFunct7 = b.f7; bus.iImm = b.imm; bus.iLast = b.last;
      bus.iValid = 1'b1;
      for (int t = 0; t < 3 && !bus.oReady; t++) cyc();
      acc = bus.oReady;
      if (acc) cyc();
      bus.iValid = 1'b0;
   endtask

   task automatic run_load(input int gap_pct, input bit poke);
      bit          a;
      logic [31:0] x;
      wq.delete();
      iStart = 1'b1;
      cyc();
      iStart = 1'b0;
      chk("start_busy", oBusy, 1);
      chk("start_count", oCount, 0);
      chk("start_error", oError, 0);
      chk("start_done", oDone, 0);
      acc_cnt = 0; rej_cnt = 0;
      for (int i = 0; i < beats.size(); i++) begin
         for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
            if (poke && i > 0) iStart = 1'b1;
            cyc();
            iStart = 1'b0;
         end
         send(beats[i], a);
         if (a) acc_cnt++; else rej_cnt++;
      end
      for (int t = 0; t < 40 && !oDone; t++) cyc();
      chk("done", oDone, 1);
      cyc();
      model();
      chk("accepted", acc_cnt, exp_acc);
      chk("rejected", rej_cnt, beats.size() - exp_acc);
      chk("count", oCount, exp_cnt);
      chk("error", oError, exp_err);
      chk("busy_end", oBusy, 0);
      chk("n_writes", wq.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
         chk($sformatf("waddr[%0d]", i), wq[i][35:32], exp_w[i][35:32]);
         chk($sformatf("wdata[%0d]", i), wq[i][31:0], exp_w[i][31:0]);
      end
      x = '0;
      foreach (exp_w[i]) x ^= exp_w[i][31:0];
`ifdef INST_LOADER_CHECKSUM_EN
      chk("checksum", oChecksum, x);
`endif
   endtask

   initial begin
      bit a;
      bus_idle();
      repeat (3) cyc();
      chk("rst_we", oWe, 0);
      chk("rst_waddr", oWaddr, 0);
      chk("rst_wdata", oWdata, 0);
      chk("rst_ready", bus.oReady, 0);
      chk("rst_busy", oBusy, 0);
      chk("rst_done", oDone, 0);
      chk("rst_error", oError, 0);
      chk("rst_count", oCount, 0);
      iRstN = 1'b1;
      cyc();

      // Full program of 14 instructions
      beats.delete();
      beats.push_back(mk(7'h13, 1, 1, 0, 0, 0, 10, 0));
      beats.push_back(mk(7'h13, 2, 2, 0, 0, 0, 10, 0));
      beats.push_back(mk(7'h33, 3, 2, 1, 0, 0, 0, 0));
      beats.push_back(mk(7'h33, 10, 2, 6, 0, 7'h20, 0, 0));
      beats.push_back(mk(7'h13, 13, 10, 0, 5, 0, 12'h405, 0));
      beats.push_back(mk(7'h13, 4, 0, 0, 0, 0, 5, 0));
      beats.push_back(mk(7'h33, 5, 1, 2, 4, 0, 0, 0));
      beats.push_back(mk(7'h13, 6, 5, 0, 6, 0, 15, 0));
      beats.push_back(mk(7'h33, 7, 6, 3, 7, 0, 0, 0));
      beats.push_back(mk(7'h13, 8, 7, 0, 1, 0, 2, 0));
      beats.push_back(mk(7'h33, 9, 8, 4, 6, 0, 0, 0));
      beats.push_back(mk(7'h13, 11, 9, 0, 7, 0, 12'h7f, 0));
      beats.push_back(mk(7'h33, 12, 11, 3, 2, 0, 0, 0));
      beats.push_back(mk(7'h33, 14, 10, 5, 5, 7'h20, 0, 1));
      run_load(0, 0);
      chk("prog_addi1", wq[0][31:0], 32'h00A08093);
      chk("prog_addi2", wq[1][31:0], 32'h00A10113);
      chk("prog_add", wq[2][31:0], 32'h001101B3);
      chk("prog_sub", wq[3][31:0], 32'h40610533);
      chk("prog_srai", wq[4][31:0], 32'h40555693);
      chk("prog_sra", wq[13][31:0], 32'h40555733);
      chk("prog_nop", wq[14], {4'd14, 32'h0});
      chk("prog_count", oCount, 14);
      chk("prog_done", oDone, 1);

      // Unsupported opcode on beat 2, next beat lands at address 2
      beats.delete();
      for (int i = 0; i < 6; i++) beats.push_back(rand_beat(0));
      beats[2].op = 7'h03;
      beats[5].last = 1'b1;
      run_load(20, 1);
      chk("bad_error", oError, 1);
      chk("bad_next_addr", wq[2][35:32], 2);
      chk("bad_next_data", wq[2][31:0], pack(beats[3]));

      // iLast on an unsupported beat still terminates
      beats.delete();
      for (int i = 0; i < 3; i++) beats.push_back(rand_beat(0));
      beats[2].op = 7'h23;
      beats[2].last = 1'b1;
      run_load(0, 0);
      chk("badlast_nop", wq[2], {4'd2, 32'h0});

      // iLast with zero user words: NO-OP alone at address 0
      beats.delete();
      beats.push_back(rand_beat(100));
      beats[0].last = 1'b1;
      run_load(0, 0);
      chk("empty_nwrites", wq.size(), 1);
      chk("empty_nop", wq[0], {4'd0, 32'h0});

      // Capacity: 20 beats without iLast
      beats.delete();
      for (int i = 0; i < 20; i++) beats.push_back(rand_beat(0));
      run_load(0, 0);
      chk("cap_count", oCount, 14);
      chk("cap_rejected", rej_cnt, 6);
      chk("cap_nop", wq[14], {4'd14, 32'h0});

      // Randomized loads with gaps, bad opcodes and ignored mid-load iStart
      for (int n = 0; n < 8; n++) begin
         int len;
         len = $urandom_range(14, 1);
         beats.delete();
         for (int i = 0; i < len; i++) beats.push_back(rand_beat(15));
         beats[len-1].last = 1'b1;
         run_load(30, 1);
      end

      // Reset in the middle of a load
      beats.delete();
      for (int i = 0; i < 8; i++) beats.push_back(rand_beat(0));
      wq.delete();
      iStart = 1'b1;
      cyc();
      iStart = 1'b0;
      for (int i = 0; i < 5; i++) send(beats[i], a);
      iRstN = 1'b0;
      cyc();
      chk("mid_rst_we", oWe, 0);
      chk("mid_rst_waddr", oWaddr, 0);
      chk("mid_rst_wdata", oWdata, 0);
      chk("mid_rst_ready", bus.oReady, 0);
      chk("mid_rst_busy", oBusy, 0);
      chk("mid_rst_done", oDone, 0);
      chk("mid_rst_error", oError, 0);
      chk("mid_rst_count", oCount, 0);
`ifdef INST_LOADER_CHECKSUM_EN
      chk("mid_rst_checksum", oChecksum, 0);
`endif
      cyc();
      iRstN = 1'b1;
      repeat (3) cyc();
      chk("mid_rst_nwrites", wq.size(), 5);
      chk("mid_rst_last", wq[4], {4'd4, pack(beats[4])});

      // Normal load after the aborted one
      beats.delete();
      for (int i = 0; i < 5; i++) beats.push_back(rand_beat(10));
      beats[4].last = 1'b1;
      run_load(20, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
